request_unit: RTL and testbench

REQUEST_UNIT -- requirements
Module: request_unit

---
 rtl/cpu_types_pkg.sv | 20 ++
 rtl/request_unit_link_register.sv | 57 +++++
 rtl/request_unit.sv | 183 ++++++++++++++++++
 tb/tb_request_unit.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg
// Shared CPU types for the memory request path.
//   word_t     : 32-bit machine word (addresses, data)
//   reqstate_t : request_unit FSM states
// -----------------------------------------------------------------------------
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DREQ   = 2'd1,
        SCFAIL = 2'd2,
        HALTED = 2'd3
    } reqstate_t;

endpackage

// File: rtl/request_unit_link_register.sv
// -----------------------------------------------------------------------------
// link_register
// Load-linked reservation: one valid bit plus the reserved word address.
// Only present when LLSC_EN is defined.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (clears the reservation)
//   ll_done    : an LL access completed this cycle -> reserve addr
//   wr_done    : a write access completed this cycle -> drop reservation if
//                it hit the reserved address
//   addr       : current data address
//   link_match : reservation valid and addr equals the reserved address
// -----------------------------------------------------------------------------
`ifdef LLSC_EN
module link_register
    import cpu_types_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  ll_done,
    input  logic  wr_done,
    input  word_t addr,
    output logic  link_match
);

    logic  link_valid_q, link_valid_d;
    word_t link_addr_q, link_addr_d;

    // Next reservation: LL sets it, any completed write to the reserved
    // address (including a successful SC) clears it.
    always_comb begin
        link_valid_d = link_valid_q;
        link_addr_d  = link_addr_q;
        if (ll_done) begin
            link_valid_d = 1'b1;
            link_addr_d  = addr;
        end else if (wr_done && (addr == link_addr_q)) begin
            link_valid_d = 1'b0;
        end else begin
            link_valid_d = link_valid_q;
        end
    end

    // Reservation registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            link_valid_q <= 1'b0;
            link_addr_q  <= '0;
        end else begin
            link_valid_q <= link_valid_d;
            link_addr_q  <= link_addr_d;
        end
    end

    assign link_match = link_valid_q && (addr == link_addr_q);

endmodule
`endif

// File: rtl/request_unit.sv
// -----------------------------------------------------------------------------
// request_unit
// Turns decoded memory/halt requests into registered cache enables. A data
// request is accepted only together with an instruction fetch completion
// (ihit) and held until the data access completes (dhit).
// Optional feature: define LLSC_EN to compile in LL/SC support via
// link_register; otherwise ll/sc act as plain load/store and sc_success is 1.
// Ports:
//   CLK, RST              : clock, synchronous active-high reset
//   ihit, dhit            : instruction / data access complete
//   MemRead, MemWrite     : decoded load / store
//   halt_in               : decoded halt
//   ll, sc                : decoded load-linked / store-conditional
//   daddr                 : data address
//   imemREN               : instruction read enable (0 only when halted)
//   dmemREN, dmemWEN      : registered data read / write enables
//   halt                  : registered sticky halt
//   sc_success            : SC outcome written to rt
// -----------------------------------------------------------------------------
module request_unit
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        halt_in,
    input  logic        ll,
    input  logic        sc,
    input  logic [31:0] daddr,
    output logic        imemREN,
    output logic        dmemREN,
    output logic        dmemWEN,
    output logic        halt,
    output logic        sc_success
);

    reqstate_t state_q, state_d;
    logic      dmem_ren_q, dmem_ren_d;
    logic      dmem_wen_q, dmem_wen_d;
    logic      halt_q, halt_d;
    logic      imem_ren_q, imem_ren_d;

    logic      rd_req;
    logic      wr_req;

    // LL is a read and SC a write as far as the cache is concerned.
    assign rd_req = MemRead | ll;
    assign wr_req = MemWrite | sc;

`ifdef LLSC_EN
    logic sc_success_q, sc_success_d;
    logic is_ll_q, is_ll_d;
    logic link_match;
    logic access_done;

    assign access_done = (state_q == DREQ) && dhit;

    link_register u_link_register (
        .clk        (CLK),
        .rst        (RST),
        .ll_done    (access_done && is_ll_q),
        .wr_done    (access_done && dmem_wen_q),
        .addr       (daddr),
        .link_match (link_match)
    );
`else
    logic unused_daddr;
    assign unused_daddr = ^daddr;
`endif

    // Next state and next enables.
    always_comb begin
        state_d    = state_q;
        dmem_ren_d = dmem_ren_q;
        dmem_wen_d = dmem_wen_q;
        halt_d     = halt_q;
`ifdef LLSC_EN
        sc_success_d = sc_success_q;
        is_ll_d      = is_ll_q;
`endif
        case (state_q)
            IDLE: begin
                // Halt outranks any memory request decoded with it.
                if (ihit && halt_in) begin
                    state_d    = HALTED;
                    halt_d     = 1'b1;
                    dmem_ren_d = 1'b0;
                    dmem_wen_d = 1'b0;
                end
`ifdef LLSC_EN
                else if (ihit && sc && !link_match) begin
                    state_d      = SCFAIL;
                    sc_success_d = 1'b0;
                end
`endif
                else if (ihit && (rd_req || wr_req)) begin
                    state_d    = DREQ;
                    dmem_ren_d = rd_req & ~wr_req;
                    dmem_wen_d = wr_req;
`ifdef LLSC_EN
                    is_ll_d = ll & ~wr_req;
                    // Success is decided at issue; the reservation cannot
                    // change before this write completes.
                    if (sc) begin
                        sc_success_d = 1'b1;
                    end else begin
                        sc_success_d = sc_success_q;
                    end
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            DREQ: begin
                if (dhit) begin
                    state_d    = IDLE;
                    dmem_ren_d = 1'b0;
                    dmem_wen_d = 1'b0;
                end else begin
                    state_d = DREQ;
                end
            end
            SCFAIL: begin
                state_d = IDLE;
            end
            HALTED: begin
                state_d    = HALTED;
                dmem_ren_d = 1'b0;
                dmem_wen_d = 1'b0;
                halt_d     = 1'b1;
            end
            default: begin
                state_d    = IDLE;
                dmem_ren_d = 1'b0;
                dmem_wen_d = 1'b0;
            end
        endcase
        imem_ren_d = (state_d != HALTED);
    end

    // State and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            dmem_ren_q <= 1'b0;
            dmem_wen_q <= 1'b0;
            halt_q     <= 1'b0;
            imem_ren_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            dmem_ren_q <= dmem_ren_d;
            dmem_wen_q <= dmem_wen_d;
            halt_q     <= halt_d;
            imem_ren_q <= imem_ren_d;
        end
    end

`ifdef LLSC_EN
    // LL/SC bookkeeping registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sc_success_q <= 1'b0;
            is_ll_q      <= 1'b0;
        end else begin
            sc_success_q <= sc_success_d;
            is_ll_q      <= is_ll_d;
        end
    end

    assign sc_success = sc_success_q;
`else
    assign sc_success = 1'b1;
`endif

    assign imemREN = imem_ren_q;
    assign dmemREN = dmem_ren_q;
    assign dmemWEN = dmem_wen_q;
    assign halt    = halt_q;

endmodule

// File: tb/tb_request_unit.sv
// -----------------------------------------------------------------------------
// tb_request_unit
// Self-checking bench for request_unit. Expected {dmemREN,dmemWEN,halt}
// triples are queued when a request is driven and popped when the registered
// outputs respond. LL/SC scenarios follow LLSC_EN.
// -----------------------------------------------------------------------------
module tb_request_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ihit, dhit, MemRead, MemWrite, halt_in, ll, sc;
    logic [31:0] daddr;
    logic        imemREN, dmemREN, dmemWEN, halt, sc_success;

    localparam logic [2:0] EXP_NONE = 3'b000;
    localparam logic [2:0] EXP_RD   = 3'b100;
    localparam logic [2:0] EXP_WR   = 3'b010;
    localparam logic [2:0] EXP_HALT = 3'b001;

`ifdef LLSC_EN
    localparam logic SC_RESET = 1'b0;
`else
    localparam logic SC_RESET = 1'b1;
`endif

    logic [2:0] sb_q[$];
    int checks = 0;
    int errors = 0;

    request_unit dut (
        .CLK        (CLK),
        .RST        (RST),
        .ihit       (ihit),
        .dhit       (dhit),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .halt_in    (halt_in),
        .ll         (ll),
        .sc         (sc),
        .daddr      (daddr),
        .imemREN    (imemREN),
        .dmemREN    (dmemREN),
        .dmemWEN    (dmemWEN),
        .halt       (halt),
        .sc_success (sc_success)
    );

    always #5 CLK = ~CLK;

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        ihit = 1'b0; dhit = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        halt_in = 1'b0; ll = 1'b0; sc = 1'b0;
    endtask

    // Present one request with ihit for a single edge and queue its expected result.
    task automatic issue(input logic rd, input logic wr, input logic hi,
                         input logic l, input logic s, input logic [31:0] a,
                         input logic [2:0] e);
        ihit = 1'b1; MemRead = rd; MemWrite = wr; halt_in = hi; ll = l; sc = s;
        daddr = a;
        sb_q.push_back(e);
        cyc();
        idle_inputs();
    endtask

    // Complete the outstanding data access with a single dhit edge.
    task automatic pulse_dhit();
        dhit = 1'b1;
        cyc();
        dhit = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        daddr = 32'h0;
        RST = 1'b1;
        cyc();
        cyc();
        checks++;
        if ({dmemREN, dmemWEN, halt, imemREN, sc_success} !== {3'b000, 1'b1, SC_RESET}) begin
            errors++;
            $display("FAIL reset_state: got ren/wen/halt/iren/sc=%b expected %b",
                     {dmemREN, dmemWEN, halt, imemREN, sc_success}, {3'b000, 1'b1, SC_RESET});
        end
        RST = 1'b0;
        cyc();
        checks++;
        if (imemREN !== 1'b1) begin
            errors++;
            $display("FAIL reset_imemren: got %b expected 1", imemREN);
        end
    endtask

    task automatic test_no_ihit();
        logic quiet = 1'b1;
        MemRead = 1'b1; MemWrite = 1'b1; halt_in = 1'b1; ihit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            if ({dmemREN, dmemWEN, halt, imemREN} !== 4'b0001) quiet = 1'b0;
        end
        idle_inputs();
        checks++;
        if (quiet !== 1'b1) begin
            errors++;
            $display("FAIL no_ihit_ignored: got ren/wen/halt/iren=%b expected 0001",
                     {dmemREN, dmemWEN, halt, imemREN});
        end
    endtask

    task automatic test_load();
        logic [2:0] e;
        logic stable = 1'b1;
        issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0100, EXP_RD);
        e = sb_q.pop_front();
        checks++;
        if ({dmemREN, dmemWEN, halt} !== e) begin
            errors++;
            $display("FAIL load_issue: got ren/wen/halt=%b expected %b", {dmemREN, dmemWEN, halt}, e);
        end
        for (int i = 0; i < 2; i++) begin
            cyc();
            if ({dmemREN, dmemWEN} !== 2'b10) stable = 1'b0;
        end
        checks++;
        if (stable !== 1'b1) begin
            errors++;
            $display("FAIL load_hold: got ren/wen=%b expected 10", {dmemREN, dmemWEN});
        end
        // dhit with a coincident fetch and store: the store must not be taken.
        dhit = 1'b1; ihit = 1'b1; MemWrite = 1'b1;
        cyc();
        idle_inputs();
        checks++;
        if ({dmemREN, dmemWEN} !== 2'b00) begin
            errors++;
            $display("FAIL load_release: got ren/wen=%b expected 00", {dmemREN, dmemWEN});
        end
        cyc();
        checks++;
        if ({dmemREN, dmemWEN} !== 2'b00) begin
            errors++;
            $display("FAIL load_dhit_priority: got ren/wen=%b expected 00", {dmemREN, dmemWEN});
        end
    endtask

    task automatic test_store_both();
        logic [2:0] e;
        logic stable = 1'b1;
        issue(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0200, EXP_WR);
        e = sb_q.pop_front();
        checks++;
        if ({dmemREN, dmemWEN, halt} !== e) begin
            errors++;
            $display("FAIL store_both_issue: got ren/wen/halt=%b expected %b", {dmemREN, dmemWEN, halt}, e);
        end
        // Requests and halt during DREQ are ignored.
        ihit = 1'b1; MemRead = 1'b1; halt_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            if ({dmemREN, dmemWEN, halt} !== EXP_WR) stable = 1'b0;
        end
        idle_inputs();
        checks++;
        if (stable !== 1'b1) begin
            errors++;
            $display("FAIL store_both_hold: got ren/wen/halt=%b expected 010", {dmemREN, dmemWEN, halt});
        end
        pulse_dhit();
        checks++;
        if ({dmemREN, dmemWEN, halt} !== EXP_NONE) begin
            errors++;
            $display("FAIL store_both_release: got ren/wen/halt=%b expected 000", {dmemREN, dmemWEN, halt});
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] e;
        issue(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0300, EXP_WR);
        e = sb_q.pop_front();
        checks++;
        if ({dmemREN, dmemWEN, halt} !== e) begin
            errors++;
            $display("FAIL b2b_first: got ren/wen/halt=%b expected %b", {dmemREN, dmemWEN, halt}, e);
        end
        pulse_dhit();
        issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0304, EXP_RD);
        e = sb_q.pop_front();
        checks++;
        if ({dmemREN, dmemWEN, halt} !== e) begin
            errors++;
            $display("FAIL b2b_second: got ren/wen/halt=%b expected %b", {dmemREN, dmemWEN, halt}, e);
        end
        pulse_dhit();
        checks++;
        if ({dmemREN, dmemWEN} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_release: got ren/wen=%b expected 00", {dmemREN, dmemWEN});
        end
    endtask

    task automatic test_reset_mid_access();
        logic [2:0] e;
        issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0400, EXP_RD);
        e = sb_q.pop_front();
        checks++;
        if ({dmemREN, dmemWEN, halt} !== e) begin
            errors++;
            $display("FAIL rst_mid_issue: got ren/wen/halt=%b expected %b", {dmemREN, dmemWEN, halt}, e);
        end
        RST = 1'b1;
        cyc();
        RST = 1'b0;
        checks++;
        if ({dmemREN, dmemWEN, halt, imemREN} !== 4'b0001) begin
            errors++;
            $display("FAIL rst_mid_abort: got ren/wen/halt/iren=%b expected 0001",
                     {dmemREN, dmemWEN, halt, imemREN});
        end
        // Back in IDLE: a fresh store is accepted immediately.
        issue(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0404, EXP_WR);
        e = sb_q.pop_front();
        checks++;
        if ({dmemREN, dmemWEN, halt} !== e) begin
            errors++;
            $display("FAIL rst_mid_idle: got ren/wen/halt=%b expected %b", {dmemREN, dmemWEN, halt}, e);
        end
        pulse_dhit();
    endtask

    task automatic test_llsc();
        logic [2:0] e;
`ifdef LLSC_EN
        // LL then matching SC succeeds; a repeated SC fails.
        issue(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0040, EXP_RD);
        e = sb_q.pop_front();
        checks++;
        if ({dmemREN, dmemWEN, halt} !== e) begin
            errors++;
            $display("FAIL ll_issue: got ren/wen/halt=%b expected %b", {dmemREN, dmemWEN, halt}, e);
        end
        pulse_dhit();
        issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0040, EXP_WR);
        e = sb_q.pop_front();
        checks++;
        if ({dmemREN, dmemWEN, halt, sc_success} !== {e, 1'b1}) begin
            errors++;
            $display("FAIL sc_success_issue: got ren/wen/halt/sc=%b expected %b",
                     {dmemREN, dmemWEN, halt, sc_success}, {e, 1'b1});
        end
        pulse_dhit();
        issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0040, EXP_NONE);
        e = sb_q.pop_front();
        checks++;
        if ({dmemREN, dmemWEN, halt, sc_success} !== {e, 1'b0}) begin
            errors++;
            $display("FAIL sc_repeat_fail: got ren/wen/halt/sc=%b expected %b",
                     {dmemREN, dmemWEN, halt, sc_success}, {e, 1'b0});
        end
        cyc();
        // SCFAIL lasted one cycle: a load is accepted now.
        issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0080, EXP_RD);
        e = sb_q.pop_front();
        checks++;
        if ({dmemREN, dmemWEN, halt} !== e) begin
            errors++;
            $display("FAIL scfail_to_idle: got ren/wen/halt=%b expected %b", {dmemREN, dmemWEN, halt}, e);
        end
        pulse_dhit();
        // An intervening store to the linked address breaks the link.
        issue(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0040, EXP_RD);
        void'(sb_q.pop_front());
        pulse_dhit();
        issue(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0040, EXP_WR);
        void'(sb_q.pop_front());
        pulse_dhit();
        issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0040, EXP_NONE);
        e = sb_q.pop_front();
        checks++;
        if ({dmemREN, dmemWEN, halt, sc_success} !== {e, 1'b0}) begin
            errors++;
            $display("FAIL sc_after_sw: got ren/wen/halt/sc=%b expected %b",
                     {dmemREN, dmemWEN, halt, sc_success}, {e, 1'b0});
        end
        cyc();
`else
        // Without link tracking LL is a load and SC a store that always succeeds.
        issue(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0040, EXP_RD);
        e = sb_q.pop_front();
        checks++;
        if ({dmemREN, dmemWEN, halt} !== e) begin
            errors++;
            $display("FAIL ll_as_read: got ren/wen/halt=%b expected %b", {dmemREN, dmemWEN, halt}, e);
        end
        pulse_dhit();
        issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0044, EXP_WR);
        e = sb_q.pop_front();
        checks++;
        if ({dmemREN, dmemWEN, halt, sc_success} !== {e, 1'b1}) begin
            errors++;
            $display("FAIL sc_as_write: got ren/wen/halt/sc=%b expected %b",
                     {dmemREN, dmemWEN, halt, sc_success}, {e, 1'b1});
        end
        pulse_dhit();
`endif
        checks++;
        if ({dmemREN, dmemWEN} !== 2'b00) begin
            errors++;
            $display("FAIL llsc_release: got ren/wen=%b expected 00", {dmemREN, dmemWEN});
        end
    endtask

    task automatic test_halt();
        logic [2:0] e;
        logic sticky = 1'b1;
        issue(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0500, EXP_HALT);
        e = sb_q.pop_front();
        checks++;
        if ({dmemREN, dmemWEN, halt, imemREN} !== {e, 1'b0}) begin
            errors++;
            $display("FAIL halt_enter: got ren/wen/halt/iren=%b expected %b",
                     {dmemREN, dmemWEN, halt, imemREN}, {e, 1'b0});
        end
        ihit = 1'b1; MemRead = 1'b1; MemWrite = 1'b1; dhit = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if ({dmemREN, dmemWEN, halt, imemREN} !== 4'b0010) sticky = 1'b0;
        end
        idle_inputs();
        checks++;
        if (sticky !== 1'b1) begin
            errors++;
            $display("FAIL halt_sticky: got ren/wen/halt/iren=%b expected 0010",
                     {dmemREN, dmemWEN, halt, imemREN});
        end
        RST = 1'b1;
        cyc();
        RST = 1'b0;
        checks++;
        if ({dmemREN, dmemWEN, halt, imemREN} !== 4'b0001) begin
            errors++;
            $display("FAIL halt_reset: got ren/wen/halt/iren=%b expected 0001",
                     {dmemREN, dmemWEN, halt, imemREN});
        end
    endtask

    initial begin
        RST = 1'b1;
        idle_inputs();
        daddr = 32'h0;
        test_reset();
        test_no_ihit();
        test_load();
        test_store_both();
        test_back_to_back();
        test_reset_mid_access();
        test_llsc();
        test_halt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
